// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/sub result stage.
// Flag bit positions, saturation limits and the result entry record.
package addsub_pkg;

  localparam int NFLAGS = 4;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  localparam int MAX_W     = 64;
  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic [NFLAGS-1:0]    flags;
  } res_entry_t;

  // Largest positive two's complement value of width w.
  function automatic logic [MAX_W-1:0] sat_max(input int w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

  // Most negative two's complement value of width w.
  function automatic logic [MAX_W-1:0] sat_min(input int w);
    return MAX_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/addsub_result_stage_fifo.sv
// Synchronous circular FIFO with valid/ready on both sides.
// Ports: push_* (write side), pop_* (read side, head shown from mem).
module result_fifo
  import addsub_pkg::*;
#(
  parameter int W     = 20,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  occ_e          occ;
  logic          push;
  logic          pop;

  always_comb begin
    occ = OCC_PARTIAL;
    unique case (1'b1)
      (count_q == '0):     occ = OCC_EMPTY;
      (count_q == FULL_C): occ = OCC_FULL;
      default:             occ = OCC_PARTIAL;
    endcase
  end

  // Ready depends on registered occupancy only.
  assign push_ready = (occ != OCC_FULL);
  assign pop_valid  = (occ != OCC_EMPTY);
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;
  // Empty FIFO still shows the last slot, never X.
  assign pop_data   = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/addsub_result_stage.sv
// Result stage after the CLA add/sub: flags, saturation, sticky V, FIFO.
// Ports: in_* from adder, out_*/res_data/flag_* to writeback, sticky_v.
module addsub_result_stage
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic             as,
  input  logic             sat_en,
  input  logic             clr_sticky,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             sticky_v
);

  localparam int EW = WIDTH + NFLAGS;
  localparam logic [MAX_W-1:0] SMAX = sat_max(WIDTH);
  localparam logic [MAX_W-1:0] SMIN = sat_min(WIDTH);

  logic              b_eff;
  logic              v;
  logic              c;
  logic              sat;
  logic [WIDTH-1:0]  res;
  logic [NFLAGS-1:0] flags;
  logic [EW-1:0]     wr_entry;
  logic [EW-1:0]     rd_entry;
  logic              accept;
  logic              sticky_q, sticky_d;

  always_comb begin
    b_eff = b_msb ^ as;
    v     = (a_msb == b_eff) && (sum[WIDTH-1] != a_msb);
    // Carry on add, borrow on subtract.
    c     = cout ^ as;
    sat   = sat_en && v;
    res   = sum;
    if (sat) begin
      res = a_msb ? SMIN[WIDTH-1:0] : SMAX[WIDTH-1:0];
    end
    flags         = '0;
    flags[FLAG_Z] = (res == '0);
    flags[FLAG_N] = res[WIDTH-1];
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
    wr_entry      = {res, flags};
  end

  assign accept = in_valid && in_ready;

  result_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (wr_entry),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (rd_entry)
  );

  assign res_data = rd_entry[EW-1:NFLAGS];
  assign flag_z   = rd_entry[FLAG_Z];
  assign flag_n   = rd_entry[FLAG_N];
  assign flag_c   = rd_entry[FLAG_C];
  assign flag_v   = rd_entry[FLAG_V];

  // Set beats clear when both happen together.
  always_comb begin
    sticky_d = sticky_q;
    if (clr_sticky) begin
      sticky_d = 1'b0;
    end
    if (accept && v) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_v = sticky_q;

endmodule

// File: tb/tb_addsub_result_stage.sv
// Directed bench for addsub_result_stage.
// Packs {out_valid,res_data,z,n,c,v,sticky} and compares to hand values.
module tb_addsub_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] sum;
  logic        cout, a_msb, b_msb, as, sat_en, clr_sticky;
  logic        out_valid, out_ready;
  logic [15:0] res_data;
  logic        flag_z, flag_n, flag_c, flag_v, sticky_v;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  addsub_result_stage #(.WIDTH(16), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sum        (sum),
    .cout       (cout),
    .a_msb      (a_msb),
    .b_msb      (b_msb),
    .as         (as),
    .sat_en     (sat_en),
    .clr_sticky (clr_sticky),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .res_data   (res_data),
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .flag_c     (flag_c),
    .flag_v     (flag_v),
    .sticky_v   (sticky_v)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] s, input logic co,
                       input logic am, input logic bm,
                       input logic a_s, input logic se);
    in_valid = 1'b1;
    sum      = s;
    cout     = co;
    a_msb    = am;
    b_msb    = bm;
    as       = a_s;
    sat_en   = se;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    sum      = 16'h0;
    cout     = 1'b0;
    a_msb    = 1'b0;
    b_msb    = 1'b0;
    as       = 1'b0;
    sat_en   = 1'b0;
  endtask

  // Pop whatever is at the head, then return to stall.
  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [21:0] got;
    rst_n      = 1'b0;
    clr_sticky = 1'b0;
    out_ready  = 1'b0;
    idle();
    #12;
    got = {out_valid, res_data, flag_z, flag_n, flag_c, flag_v, sticky_v};
    tests++;
    if (got !== 22'h0) begin
      fails++;
      $display("FAIL reset_out got=%h exp=%h", got, 22'h0);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_overflow_nosat();
    logic [21:0] got;
    logic [21:0] exp;
    drive(16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    got = {out_valid, res_data, flag_z, flag_n, flag_c, flag_v, sticky_v};
    exp = {1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL ovf_nosat got=%h exp=%h", got, exp);
    end
    pop_one();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL ovf_nosat_pop got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_saturation();
    logic [21:0] got;
    logic [21:0] exp;
    drive(16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    idle();
    got = {out_valid, res_data, flag_z, flag_n, flag_c, flag_v, sticky_v};
    exp = {1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL sat_pos got=%h exp=%h", got, exp);
    end
    pop_one();
    drive(16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    idle();
    got = {out_valid, res_data, flag_z, flag_n, flag_c, flag_v, sticky_v};
    exp = {1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL sat_neg got=%h exp=%h", got, exp);
    end
    pop_one();
  endtask

  task automatic test_sub_flags();
    logic [21:0] got;
    logic [21:0] exp;
    drive(16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    idle();
    got = {out_valid, res_data, flag_z, flag_n, flag_c, flag_v, sticky_v};
    exp = {1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL sub_zero got=%h exp=%h", got, exp);
    end
    pop_one();
    drive(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    idle();
    got = {out_valid, res_data, flag_z, flag_n, flag_c, flag_v, sticky_v};
    exp = {1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL sub_borrow got=%h exp=%h", got, exp);
    end
    pop_one();
  endtask

  task automatic test_sticky();
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    tests++;
    if (sticky_v !== 1'b0) begin
      fails++;
      $display("FAIL sticky_clr1 got=%b exp=0", sticky_v);
    end
    drive(16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clr_sticky = 1'b1;
    step();
    idle();
    clr_sticky = 1'b0;
    tests++;
    if (sticky_v !== 1'b1) begin
      fails++;
      $display("FAIL sticky_set_wins got=%b exp=1", sticky_v);
    end
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    tests++;
    if (sticky_v !== 1'b0) begin
      fails++;
      $display("FAIL sticky_clr2 got=%b exp=0", sticky_v);
    end
    pop_one();
  endtask

  task automatic test_back_to_back();
    logic [17:0] got;
    out_ready = 1'b0;
    drive(16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    got = {in_ready, out_valid, res_data};
    tests++;
    if (got !== {2'b01, 16'h1111}) begin
      fails++;
      $display("FAIL b2b_full got=%h exp=%h", got, {2'b01, 16'h1111});
    end
    drive(16'h3333, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    got = {in_ready, out_valid, res_data};
    tests++;
    if (got !== {2'b01, 16'h1111}) begin
      fails++;
      $display("FAIL b2b_hold got=%h exp=%h", got, {2'b01, 16'h1111});
    end
    out_ready = 1'b1;
    step();
    got = {in_ready, out_valid, res_data};
    tests++;
    if (got !== {2'b11, 16'h2222}) begin
      fails++;
      $display("FAIL b2b_pop_a got=%h exp=%h", got, {2'b11, 16'h2222});
    end
    step();
    idle();
    got = {in_ready, out_valid, res_data};
    tests++;
    if (got !== {2'b11, 16'h3333}) begin
      fails++;
      $display("FAIL b2b_pushpop got=%h exp=%h", got, {2'b11, 16'h3333});
    end
    step();
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    logic [2:0]  got;
    logic [17:0] got2;
    out_ready = 1'b0;
    drive(16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    got = {out_valid, in_ready, sticky_v};
    tests++;
    if (got !== 3'b010) begin
      fails++;
      $display("FAIL async_rst got=%b exp=010", got);
    end
    step();
    rst_n = 1'b1;
    drive(16'h4444, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    got2 = {out_valid, in_ready, res_data};
    tests++;
    if (got2 !== {2'b11, 16'h4444}) begin
      fails++;
      $display("FAIL post_rst_head got=%h exp=%h", got2, {2'b11, 16'h4444});
    end
    pop_one();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL post_rst_stale got=%b exp=0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_overflow_nosat();
    test_saturation();
    test_sub_flags();
    test_sticky();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
